duty_ramp_generator: RTL

Upstream stage of the LED PWM path. Produces a "breathing" duty-cycle value that ramps between a floor and a ceiling, holds at each extreme, and reverses. It runs its own period counter with the same 0..PERIOD count the PWM comparator uses, and changes the duty value only at period boundaries, so the comparator never sees a mid-period change. An optional one-shot load interface jumps the duty to an arbitrary value.

---
 rtl/duty_ramp_generator.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/duty_ramp_generator.sv
// duty_ramp_generator
//
// Breathing duty-cycle source for the LED PWM path. Runs its own 0..PERIOD
// period counter, the same count the PWM comparator uses. The duty value
// ramps from MIN_DUTY up to MAX_DUTY, holds there, ramps back down, holds,
// and repeats. Duty, state and hold count change only at a period boundary
// (pcnt == PERIOD), so the comparator never sees a change in mid-period.
// A one-shot load handshake lets software jump the duty to any value. The
// value is clamped to the rails, and ramping then resumes upward.
//
// Ports
//   clock         rising-edge clock
//   reset_n       asynchronous active-low reset
//   enable        run request, sampled only at boundaries
//   set_valid     load request
//   set_duty      load value (clamped to MIN_DUTY..MAX_DUTY when applied)
//   set_ready     high when a load can be accepted (no load pending)
//   duty_cycle    registered duty value for the PWM comparator
//   period_start  high while the period counter is 0
//   ramp_state    current state encoding (debug)

module duty_ramp_generator #(
    parameter int PERIOD       = 100,
    parameter int MIN_DUTY     = 0,
    parameter int MAX_DUTY     = 100,
    parameter int STEP         = 5,
    parameter int HOLD_PERIODS = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       set_valid,
    input  logic [7:0] set_duty,
    output logic       set_ready,
    output logic [7:0] duty_cycle,
    output logic       period_start,
    output logic [2:0] ramp_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } state_t;

    localparam logic [7:0] PERIOD_L  = 8'(PERIOD);
    localparam logic [7:0] MIN_D     = 8'(MIN_DUTY);
    localparam logic [7:0] MAX_D     = 8'(MAX_DUTY);
    localparam logic [7:0] STEP_D    = 8'(STEP);
    localparam logic [8:0] MIN_W     = 9'(MIN_DUTY);
    localparam logic [8:0] MAX_W     = 9'(MAX_DUTY);
    localparam logic [8:0] STEP_W    = 9'(STEP);
    // The last hold count before leaving a hold state. It is unused when
    // HOLD_PERIODS is 0, because the hold states are then skipped entirely.
    localparam logic [7:0] HOLD_LAST = (HOLD_PERIODS == 0) ? 8'd0 : 8'(HOLD_PERIODS - 1);
    localparam bit         NO_HOLD   = (HOLD_PERIODS == 0);

    state_t     state;
    logic [7:0] pcnt;
    logic [7:0] hcnt;
    logic       pending;
    logic [7:0] load_val;

    logic       boundary;
    logic [8:0] up_sum;
    logic [8:0] down_limit;
    logic [7:0] load_clamped;

    assign boundary   = (pcnt == PERIOD_L);
    // 9-bit sums, so duty+STEP and MIN+STEP cannot wrap and saturation is exact.
    assign up_sum     = {1'b0, duty_cycle} + STEP_W;
    assign down_limit = MIN_W + STEP_W;

    // A value that equals a rail clamps to that same rail, so <= and >= give
    // the right result here.
    always_comb begin
        load_clamped = load_val;
        if (load_val <= MIN_D)
            load_clamped = MIN_D;
        else if (load_val >= MAX_D)
            load_clamped = MAX_D;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every register is reset here, including the load data
            // register. Nothing in this block is a memory array, so a full
            // reset costs nothing and keeps the state free of X after reset.
            pcnt       <= 8'd0;
            state      <= IDLE;
            duty_cycle <= MIN_D;
            hcnt       <= 8'd0;
            pending    <= 1'b0;
            load_val   <= 8'd0;
        end else begin
            // NOTE: only non-blocking assignments are used in this block.
            // Every branch reads the register values from before the edge,
            // and when two branches assign the same register, the later
            // assignment wins (this is used for `pending` below).
            pcnt <= boundary ? 8'd0 : pcnt + 8'd1;

            if (boundary) begin
                if (!enable) begin
                    state      <= IDLE;
                    duty_cycle <= MIN_D;
                    pending    <= 1'b0;
                end else if (pending) begin
                    duty_cycle <= load_clamped;
                    state      <= RAMP_UP;
                    hcnt       <= 8'd0;
                    pending    <= 1'b0;
                end else begin
                    case (state)
                        IDLE: state <= RAMP_UP;

                        RAMP_UP: begin
                            if (up_sum >= MAX_W) begin
                                duty_cycle <= MAX_D;
                                hcnt       <= 8'd0;
                                state      <= NO_HOLD ? RAMP_DOWN : HOLD_HIGH;
                            end else begin
                                duty_cycle <= duty_cycle + STEP_D;
                            end
                        end

                        HOLD_HIGH: begin
                            if (hcnt == HOLD_LAST)
                                state <= RAMP_DOWN;
                            else
                                hcnt <= hcnt + 8'd1;
                        end

                        RAMP_DOWN: begin
                            if ({1'b0, duty_cycle} <= down_limit) begin
                                duty_cycle <= MIN_D;
                                hcnt       <= 8'd0;
                                state      <= NO_HOLD ? RAMP_UP : HOLD_LOW;
                            end else begin
                                // Cannot underflow: here duty > MIN+STEP >= STEP.
                                duty_cycle <= duty_cycle - STEP_D;
                            end
                        end

                        HOLD_LOW: begin
                            if (hcnt == HOLD_LAST)
                                state <= RAMP_UP;
                            else
                                hcnt <= hcnt + 8'd1;
                        end

                        default: state <= IDLE;
                    endcase
                end
            end

            // A load accepted in the boundary cycle sets pending after the
            // boundary logic above. It is therefore applied at the next
            // boundary, not the current one.
            if (set_valid && !pending) begin
                load_val <= set_duty;
                pending  <= 1'b1;
            end
        end
    end

    assign set_ready    = ~pending;
    assign period_start = (pcnt == 8'd0);
    assign ramp_state   = state;

endmodule
